msu_data_streamer: RTL
======================

// Module: msu_data_streamer
// PURPOSE
//  Storage-side responder for the MSU-1 data port. It takes msu_data_addr and msu_data_seek and returns
//  msu_data_in and msu_data_busy. It fetches 512-byte sectors from the storage/HPS sector channel into a
//  two-bank ping-pong buffer and serves bytes at the current address. It prefetches the next sector ahead.
//  It sits beside the MSU logic in the DSP_LHRomMap path and is clocked from MCLK.
// PARAMETERS
//  SECT_BITS  9   log2 of the sector size in bytes (512)
//  ADDR_W     32  width of the MSU data address
// PORTS
//  mclk           in   1                 system clock (MCLK); the only clock
//  rst_n          in   1                 reset, synchronous, active-low
//  msu_data_addr  in   ADDR_W            byte address the MSU wants; steps by +1 on sequential reads
//  msu_data_seek  in   1                 seek request; acted on at its rising edge
//  msu_data_in    out  8                 byte at msu_data_addr (registered)
//  msu_data_busy  out  1                 1 = data not yet valid for the current address
//  sd_lba         out  ADDR_W-SECT_BITS  sector number being requested
//  sd_rd          out  1                 sector read request; held until sd_ack
//  sd_ack         in   1                 one-cycle pulse: request accepted, byte stream follows
//  sd_wr          in   1                 strobe: one sector byte valid on sd_dout, in order 0..511
//  sd_dout        in   8                 sector byte
// BEHAVIOUR
//  Reset (rst_n=0 at a mclk edge)
//  - Outputs go to: msu_data_in=0, msu_data_busy=0, sd_rd=0, sd_lba=0.
//  - FSM goes to IDLE. Both bank valid flags and the discard flag are cleared. The byte counter goes to 0.
//  - This holds even mid-transfer. sd_wr strobes that arrive after reset are ignored until the next sd_ack.
//  Buffer
//  - 1024x8 RAM. Bank = sector LSB, so the RAM address is addr[SECT_BITS:0].
//  - Each bank has a tag (full sector number) and a valid bit.
//  - cur_sect = msu_data_addr[ADDR_W-1:SECT_BITS]. hit = bank[cur_sect[0]] is valid and its tag == cur_sect.
//  Read path
//  - msu_data_in is updated 1 cycle after the address: RAM read on addr at edge N, output at edge N+1.
//  - msu_data_busy = ~hit, registered, with the same 1-cycle latency.
//  - While busy, msu_data_in holds its last value.
//  Seek (rising edge of msu_data_seek)
//  - Clears both valid flags; busy=1 from the next cycle.
//  - If the FSM is in FETCH, it sets discard=1: the in-flight sector completes its 512 bytes, is not marked
//    valid, and a fetch of cur_sect follows.
//  - A seek on the same cycle as the 512th byte wins: that sector is discarded.
//  FSM
//  - IDLE:  if ~hit, set sd_lba=cur_sect and go to REQ. Else, if the other bank does not hold valid
//           cur_sect+1, set sd_lba=cur_sect+1 and go to REQ (prefetch). Else stay.
//  - REQ:   sd_rd=1. On sd_ack: sd_rd=0, clear the target bank's valid bit, write its tag=sd_lba,
//           cnt=0, go to FETCH.
//  - FETCH: each sd_wr writes sd_dout to RAM[{sd_lba[0],cnt}] and increments cnt.
//           cnt==511 with sd_wr: valid=~discard, discard=0, go to IDLE.
//  - sd_rd is never high outside REQ.
//  Rules
//  - Prefetch never overwrites the bank of cur_sect.
//  - Underrun: if the address steps into a sector not yet valid, busy re-asserts until that sector lands.
//  - Sector arithmetic wraps modulo 2^(ADDR_W-SECT_BITS). Byte address wrap FFFFFFFF->0 maps to sector 0.
//  - sd_wr outside FETCH is ignored. A missing sd_ack leaves the FSM in REQ indefinitely (no timeout).
// TESTING
//  1 Reset, then seek to addr 0x00000200 -> sd_rd=1 with sd_lba=1; msu_data_busy=1; after ack and 512 bytes
//    (pattern b=i^0x5A), busy=0 and msu_data_in=0x5A one cycle later.
//  2 After test 1 -> sd_rd=1 with sd_lba=2 (prefetch). Step addr 0x3FF->0x400 after prefetch done ->
//    busy stays 0; data_in=0xA5 then 0x5A.
//  3 Step addr to 0x400 before prefetch completes -> busy=1 until the 512th byte of sector 2, then 0.
//  4 Seek to 0x1000 while fetch of sector 2 is at byte 100 -> sector 2 discarded (not valid);
//    next request sd_lba=8; busy=0 only after sector 8 lands.
//  5 Seek on the same cycle as the 512th byte -> that bank stays invalid; a new request follows.
//  6 Assert rst_n=0 mid-FETCH -> next cycle sd_rd=0, busy=0, data_in=0.
//    Further sd_wr strobes do not alter RAM; a fresh seek works normally.

Source files
------------

// File: rtl/msu_data_streamer.sv
// -----------------------------------------------------------------------------
// msu_data_streamer
// Storage-side responder for the MSU-1 data port. Sectors are fetched from the
// storage sector channel into a two-bank ping-pong buffer (bank = sector LSB)
// and bytes are served at the current MSU data address. While the current
// sector is resident, the sector after it is prefetched into the other bank.
//
// Ports
//   mclk           in   system clock, the only clock
//   rst_n          in   synchronous active-low reset
//   msu_data_addr  in   byte address requested by the MSU
//   msu_data_seek  in   seek request, acted on at its rising edge
//   msu_data_in    out  byte at msu_data_addr, registered (1-cycle latency)
//   msu_data_busy  out  1 while the byte for the current address is not valid
//   sd_lba         out  sector number being requested
//   sd_rd          out  sector read request, held until sd_ack
//   sd_ack         in   one-cycle pulse: request accepted, byte stream follows
//   sd_wr          in   strobe: one sector byte valid on sd_dout (order 0..N-1)
//   sd_dout        in   sector byte
// -----------------------------------------------------------------------------
module msu_data_streamer #(
    parameter int SECT_BITS = 9,
    parameter int ADDR_W    = 32
) (
    input  logic                        mclk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           msu_data_addr,
    input  logic                        msu_data_seek,
    output logic [7:0]                  msu_data_in,
    output logic                        msu_data_busy,
    output logic [ADDR_W-SECT_BITS-1:0] sd_lba,
    output logic                        sd_rd,
    input  logic                        sd_ack,
    input  logic                        sd_wr,
    input  logic [7:0]                  sd_dout
);

    localparam int SW        = ADDR_W - SECT_BITS;
    localparam int RAM_DEPTH = 2 ** (SECT_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    // Registers
    state_t                r_state;
    logic [SW-1:0]         r_lba;
    logic                  r_rd;
    logic                  r_seek_d;
    logic [1:0]            r_valid;
    logic [SW-1:0]         r_tag [2];
    logic                  r_discard;
    logic [SECT_BITS-1:0]  r_cnt;
    logic [7:0]            r_data;
    logic                  r_busy;
    logic [7:0]            r_ram [RAM_DEPTH];

    // Wires
    state_t                w_state_nxt;
    logic [SW-1:0]         w_lba_nxt;
    logic                  w_rd_nxt;
    logic [SW-1:0]         w_cur_sect;
    logic [SW-1:0]         w_next_sect;
    logic                  w_cur_bank;
    logic                  w_oth_bank;
    logic                  w_hit;
    logic                  w_pf_hit;
    logic                  w_seek_rise;
    logic                  w_take_ack;
    logic                  w_fetch_wr;
    logic                  w_last_byte;

    assign w_cur_sect  = msu_data_addr[ADDR_W-1:SECT_BITS];
    // Sector arithmetic wraps naturally at the width of the sector number.
    assign w_next_sect = w_cur_sect + SW'(1);
    assign w_cur_bank  = w_cur_sect[0];
    assign w_oth_bank  = ~w_cur_bank;
    assign w_hit       = r_valid[w_cur_bank] && (r_tag[w_cur_bank] == w_cur_sect);
    // The other bank is always the bank of cur_sect+1, so prefetch never
    // touches the bank currently being served.
    assign w_pf_hit    = r_valid[w_oth_bank] && (r_tag[w_oth_bank] == w_next_sect);
    assign w_seek_rise = msu_data_seek && !r_seek_d;
    assign w_take_ack  = (r_state == ST_REQ) && sd_ack;
    assign w_fetch_wr  = (r_state == ST_FETCH) && sd_wr;
    assign w_last_byte = w_fetch_wr && (r_cnt == {SECT_BITS{1'b1}});

    // Next-state, next request sector and read-request decode
    always_comb begin
        w_state_nxt = r_state;
        w_lba_nxt   = r_lba;
        w_rd_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A seek in this cycle invalidates everything, so treat it as a miss.
                if (!w_hit || w_seek_rise) begin
                    w_lba_nxt   = w_cur_sect;
                    w_state_nxt = ST_REQ;
                    w_rd_nxt    = 1'b1;
                end else if (!w_pf_hit) begin
                    w_lba_nxt   = w_next_sect;
                    w_state_nxt = ST_REQ;
                    w_rd_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    w_state_nxt = ST_FETCH;
                    w_rd_nxt    = 1'b0;
                end else begin
                    w_state_nxt = ST_REQ;
                    w_rd_nxt    = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_last_byte) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, request sector, read request and seek edge detector
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_lba    <= {SW{1'b0}};
            r_rd     <= 1'b0;
            r_seek_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lba    <= w_lba_nxt;
            r_rd     <= w_rd_nxt;
            r_seek_d <= msu_data_seek;
        end
    end

    // Bank bookkeeping: byte counter, tags, valid flags and discard flag
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_cnt     <= {SECT_BITS{1'b0}};
            r_tag[0]  <= {SW{1'b0}};
            r_tag[1]  <= {SW{1'b0}};
            r_valid   <= 2'b00;
            r_discard <= 1'b0;
        end else begin
            if (w_take_ack) begin
                r_cnt            <= {SECT_BITS{1'b0}};
                r_tag[r_lba[0]]  <= r_lba;
            end else if (w_fetch_wr) begin
                r_cnt <= r_cnt + SECT_BITS'(1);
            end

            // A seek wins over everything, including a sector landing in the same cycle.
            for (int b = 0; b < 2; b++) begin
                if (w_seek_rise) begin
                    r_valid[b] <= 1'b0;
                end else if (w_take_ack && (r_lba[0] == b[0])) begin
                    r_valid[b] <= 1'b0;
                end else if (w_last_byte && (r_lba[0] == b[0])) begin
                    r_valid[b] <= ~r_discard;
                end
            end

            // The in-flight sector still streams in full but is never marked valid.
            if (w_last_byte) begin
                r_discard <= 1'b0;
            end else if (w_seek_rise && (r_state == ST_FETCH)) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Sector buffer write port
    always_ff @(posedge mclk) begin
        if (rst_n && w_fetch_wr) begin
            r_ram[{r_lba[0], r_cnt}] <= sd_dout;
        end
    end

    // Registered read path: data holds while busy
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            r_data <= 8'h00;
            r_busy <= 1'b0;
        end else if (w_seek_rise) begin
            r_busy <= 1'b1;
        end else begin
            r_busy <= ~w_hit;
            if (w_hit) begin
                r_data <= r_ram[msu_data_addr[SECT_BITS:0]];
            end
        end
    end

    assign msu_data_in   = r_data;
    assign msu_data_busy = r_busy;
    assign sd_lba        = r_lba;
    assign sd_rd         = r_rd;

endmodule
